// File: rtl/sram_byte_en_pipe.sv
// sram_byte_en_pipe
// Single-port RAM with per-column (byte) write enables, a 1- or 2-stage
// registered read path, selectable write behaviour (write-first, read-first,
// no-change) and a zero-fill sweep engine that owns the array while busy.
//
// Ports
//   clka    in   rising-edge clock
//   rsta_n  in   asynchronous active-low reset (control and output stages)
//   ena     in   access request, taken only while busy is low
//   wea     in   per-column write enables; all zero selects a read
//   addra   in   word address; out-of-range addresses never write, read zero
//   dina    in   write data
//   clr     in   single-cycle pulse that starts a zero-fill sweep
//   busy    out  sweep in progress, accesses are dropped
//   douta   out  read data, holds between updates
//   vld_o   out  one-cycle pulse marking a douta update
module sram_byte_en_pipe #(
    parameter int NB_COL       = 4,
    parameter int COL_WIDTH    = 8,
    parameter int RAM_DEPTH    = 8192,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_MODE   = 0,
    parameter int AUTO_CLEAR   = 1,
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
    localparam int DW = NB_COL * COL_WIDTH
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              ena,
    input  logic [NB_COL-1:0] wea,
    input  logic [AW-1:0]     addra,
    input  logic [DW-1:0]     dina,
    input  logic              clr,
    output logic              busy,
    output logic [DW-1:0]     douta,
    output logic              vld_o
);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    localparam state_t        RST_STATE = (AUTO_CLEAR != 0) ? CLEAR : IDLE;
    localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(RAM_DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    logic [DW-1:0] mem [RAM_DEPTH];

    logic          accept;
    logic          is_wr;
    logic          in_range;
    logic          upd;
    logic [DW-1:0] rd_old;
    logic [DW-1:0] merged;
    logic [DW-1:0] rd_word;

    logic [DW-1:0] data_p1;
    logic          vld_p1;

    assign busy     = (state == CLEAR);
    assign accept   = ena && !busy;
    assign is_wr    = |wea;
    assign in_range = ({1'b0, addra} < DEPTH_X);
    assign rd_old   = in_range ? mem[addra] : '0;

    always_comb begin
        merged = rd_old;
        for (int c = 0; c < NB_COL; c++) begin
            if (wea[c]) begin
                merged[c*COL_WIDTH +: COL_WIDTH] = dina[c*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // No-change writes produce no result; everything else returns a word.
    assign upd     = accept && (!is_wr || (WRITE_MODE != 2));
    assign rd_word = (is_wr && (WRITE_MODE == 0) && in_range) ? merged : rd_old;

    // Sweep FSM: cnt is parked at zero in IDLE so a new sweep always starts at 0.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Array is never reset. A write to mem[0] while held in reset is harmless:
    // that state only exists when a full sweep follows release.
    always_ff @(posedge clka) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (accept && is_wr && in_range) begin
            for (int c = 0; c < NB_COL; c++) begin
                if (wea[c]) begin
                    mem[addra][c*COL_WIDTH +: COL_WIDTH] <= dina[c*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // ---- stage p1: result captured at acceptance ----
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= upd;
            if (upd) begin
                data_p1 <= rd_word;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DW-1:0] data_p2;
            logic          vld_p2;

            // ---- stage p2: second output register ----
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    data_p2 <= '0;
                    vld_p2  <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        data_p2 <= data_p1;
                    end
                end
            end

            assign douta = data_p2;
            assign vld_o = vld_p2;
        end else begin : g_lat1
            assign douta = data_p1;
            assign vld_o = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_sram_byte_en_pipe.sv
// tb_sram_byte_en_pipe
// Four instances (write-first L1, read-first L2, no-change L1, write-first L2)
// share one stimulus stream. A word-level reference model (plain array plus a
// list of scheduled results) predicts douta, vld_o and busy for each instance.
module tb_sram_byte_en_pipe;

    localparam int NI = 4;
    localparam int DEPTH = 16;
    localparam int MODE [NI] = '{0, 1, 2, 0};
    localparam int LAT  [NI] = '{1, 2, 1, 2};

    logic        clka   = 1'b0;
    logic        rsta_n = 1'b1;
    logic        ena    = 1'b0;
    logic        clr    = 1'b0;
    logic [3:0]  wea    = 4'h0;
    logic [3:0]  addra  = 4'h0;
    logic [31:0] dina   = 32'h0;

    logic [31:0] douta_w [NI];
    logic        vld_w   [NI];
    logic        busy_w  [NI];

    always #5 clka = ~clka;

    sram_byte_en_pipe #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(1),
                        .WRITE_MODE(0), .AUTO_CLEAR(1)) u_wf1 (
        .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .busy(busy_w[0]), .douta(douta_w[0]), .vld_o(vld_w[0]));

    sram_byte_en_pipe #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(2),
                        .WRITE_MODE(1), .AUTO_CLEAR(1)) u_rf2 (
        .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .busy(busy_w[1]), .douta(douta_w[1]), .vld_o(vld_w[1]));

    sram_byte_en_pipe #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(1),
                        .WRITE_MODE(2), .AUTO_CLEAR(1)) u_nc1 (
        .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .busy(busy_w[2]), .douta(douta_w[2]), .vld_o(vld_w[2]));

    sram_byte_en_pipe #(.NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(DEPTH), .READ_LATENCY(2),
                        .WRITE_MODE(0), .AUTO_CLEAR(1)) u_wf2 (
        .clka(clka), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .clr(clr), .busy(busy_w[3]), .douta(douta_w[3]), .vld_o(vld_w[3]));

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } ev_t;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] held  [NI];
    ev_t         evq [$];
    int          sweep_left = 0;
    int          edge_n = 0;
    int          n_cmp = 0;
    int          n_mis = 0;

    function automatic string nm(input int i);
        case (i)
            0:       return "wf1";
            1:       return "rf2";
            2:       return "nc1";
            default: return "wf2";
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sched(input int i, input logic [31:0] d);
        ev_t ev;
        ev.inst = i;
        ev.due  = edge_n + LAT[i] - 1;
        ev.data = d;
        evq.push_back(ev);
    endtask

    // at_edge=0 is used right after an asynchronous reset, where no result can land.
    task automatic check_all(input bit at_edge);
        logic       hit;
        logic       exp_busy;
        exp_busy = !rsta_n || (sweep_left > 0);
        for (int i = 0; i < NI; i++) begin
            hit = 1'b0;
            if (at_edge) begin
                for (int j = 0; j < evq.size(); j++) begin
                    if (evq[j].inst == i && evq[j].due == edge_n) begin
                        hit     = 1'b1;
                        held[i] = evq[j].data;
                        evq.delete(j);
                        break;
                    end
                end
            end
            check($sformatf("%s_vld@%0d", nm(i), edge_n), {31'b0, vld_w[i]}, {31'b0, hit});
            check($sformatf("%s_dout@%0d", nm(i), edge_n), douta_w[i], held[i]);
            check($sformatf("%s_busy@%0d", nm(i), edge_n), {31'b0, busy_w[i]}, {31'b0, exp_busy});
        end
    endtask

    task automatic cycle(input logic e, input logic [3:0] w, input logic [3:0] a,
                         input logic [31:0] d, input logic c);
        logic [31:0] old;
        logic [31:0] mrg;
        ena = e; wea = w; addra = a; dina = d; clr = c;
        @(posedge clka);
        #1;
        edge_n++;
        if (rsta_n) begin
            if (sweep_left > 0) begin
                mem_m[DEPTH - sweep_left] = 32'h0;
                sweep_left--;
            end else begin
                if (e) begin
                    old = mem_m[a];
                    mrg = old;
                    for (int k = 0; k < 4; k++) begin
                        if (w[k]) mrg[8*k +: 8] = d[8*k +: 8];
                    end
                    if (w != 4'h0) mem_m[a] = mrg;
                    for (int i = 0; i < NI; i++) begin
                        if (w == 4'h0)       sched(i, old);
                        else if (MODE[i] == 0) sched(i, mrg);
                        else if (MODE[i] == 1) sched(i, old);
                    end
                end
                if (c) sweep_left = DEPTH;
            end
        end
        check_all(1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic enter_reset();
        rsta_n = 1'b0;
        #1;
        evq.delete();
        for (int i = 0; i < NI; i++) held[i] = 32'h0;
        check_all(1'b0);
    endtask

    task automatic leave_reset();
        #1;
        rsta_n     = 1'b1;
        sweep_left = DEPTH;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        for (int i = 0; i < NI; i++) held[i] = 32'h0;

        // power-on reset and auto-clear sweep; accesses during the sweep are dropped
        #1;
        enter_reset();
        idle(3);
        leave_reset();
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'($urandom), 4'($urandom), $urandom, 1'b0);
        cycle(1'b1, 4'h0, 4'd5, 32'h0, 1'b0);
        idle(2);

        // partial-column writes to address 3, then read back
        cycle(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0);
        cycle(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0);
        check("wf1_merge_l1", douta_w[0], 32'hAA22CC44);
        cycle(1'b1, 4'h0, 4'd3, 32'h0, 1'b0);
        check("wf2_merge_l2", douta_w[3], 32'hAA22CC44);
        check("rf2_prewrite", douta_w[1], 32'hAABBCCDD);
        check("nc1_read", douta_w[2], 32'hAA22CC44);
        cycle(1'b1, 4'hF, 4'd3, 32'h01020304, 1'b0);
        check("rf2_read3", douta_w[1], 32'hAA22CC44);
        check("nc1_hold", douta_w[2], 32'hAA22CC44);
        idle(2);

        // clr with a same-cycle read: the read still delivers pre-clear data
        cycle(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0);
        cycle(1'b1, 4'h0, 4'd2, 32'h0, 1'b1);
        check("wf1_clr_rd", douta_w[0], 32'h12345678);
        cycle(1'b1, 4'hF, 4'd2, 32'hFFFFFFFF, 1'b1);
        check("wf2_clr_rd", douta_w[3], 32'h12345678);
        for (int k = 0; k < DEPTH - 1; k++) cycle(1'b1, 4'hF, 4'($urandom), $urandom, 1'b0);
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'h0, 4'(k), 32'h0, 1'b0);
        idle(2);

        // randomized traffic with occasional sweeps
        for (int k = 0; k < 300; k++) begin
            cycle(($urandom % 4) != 0, (($urandom % 3) == 0) ? 4'h0 : 4'($urandom),
                  4'($urandom), $urandom, ($urandom % 60) == 0);
        end
        for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);

        // reset asserted mid-sweep at cnt=7, then a full restarted sweep
        cycle(1'b1, 4'hF, 4'd9, 32'hDEADBEEF, 1'b0);
        cycle(1'b1, 4'h0, 4'd9, 32'h0, 1'b0);
        idle(2);
        cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1);
        idle(7);
        #2;
        enter_reset();
        idle(2);
        leave_reset();
        for (int k = 0; k < DEPTH; k++) cycle(1'b1, 4'hF, 4'($urandom), $urandom, 1'b0);
        for (int k = 0; k < 24; k++) cycle(1'b1, 4'h0, 4'($urandom), 32'h0, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sram_byte_en_pipe.md
SRAM_BYTE_EN_PIPE -- requirements
Module: sram_byte_en_pipe

Interface
REQ-001 SHALL have parameter NB_COL, default 4: number of byte columns per word.
REQ-002 SHALL have parameter COL_WIDTH, default 8: bits per column (8 or 9).
REQ-003 SHALL have parameter RAM_DEPTH, default 8192: words; address width AW = ceil(log2(RAM_DEPTH)), minimum 1.
REQ-004 SHALL have parameter READ_LATENCY, default 1: output register stages, legal values 1 or 2.
REQ-005 SHALL have parameter WRITE_MODE, default 0: 0 write-first, 1 read-first, 2 no-change.
REQ-006 SHALL have parameter AUTO_CLEAR, default 1: 1 starts a zero-fill sweep on reset release.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: clka and rsta_n.
REQ-008 SHALL provide these ports:
- clka  in  1  clock, rising edge
- rsta_n  in  1  asynchronous active-low reset
- ena  in  1  access request
- wea  in  NB_COL  byte write enables; all zero means read
- addra  in  AW  word address
- dina  in  NB_COL*COL_WIDTH  write data
- clr  in  1  one-cycle pulse that starts a zero-fill sweep
- busy  out  1  sweep in progress; accesses not accepted
- douta  out  NB_COL*COL_WIDTH  read data
- vld_o  out  1  douta updated this cycle

Function
REQ-009 SHALL accept an access when ena=1 and busy=0; ena while busy=1 SHALL be dropped: no write, no vld_o.
REQ-010 An accepted write SHALL update only the columns whose wea bit is set; other columns SHALL keep their value.
REQ-011 Addresses >= RAM_DEPTH SHALL be ignored for writes and SHALL read as all-zero.
REQ-012 Accepted read (wea=0) SHALL present mem[addra] on douta with vld_o=1 exactly READ_LATENCY cycles after acceptance.
REQ-013 Write-first: an accepted write SHALL return the merged new word on douta, with vld_o, at READ_LATENCY.
REQ-014 Read-first: an accepted write SHALL return the pre-write word, with vld_o, at READ_LATENCY.
REQ-015 No-change: an accepted write SHALL leave douta unchanged and SHALL NOT assert vld_o.
REQ-016 douta SHALL hold its last value when no data update arrives; vld_o SHALL be a one-cycle pulse per update.
REQ-017 Back-to-back accepted accesses SHALL be fully pipelined, one per cycle, with results in issue order.
REQ-018 FSM states: IDLE and CLEAR; busy=1 exactly while in CLEAR.
REQ-019 IDLE->CLEAR on clr=1; the sweep counter SHALL be 0 at CLEAR entry.
REQ-020 In CLEAR, each cycle SHALL write all-zero to mem[cnt] and increment cnt; after writing RAM_DEPTH-1, next state SHALL be IDLE.
REQ-021 A sweep SHALL occupy exactly RAM_DEPTH cycles.
REQ-022 clr during CLEAR SHALL be ignored.
REQ-023 clr and ena in the same IDLE cycle: the access SHALL be accepted, and CLEAR SHALL begin the next cycle.
REQ-024 Reads accepted before CLEAR entry SHALL still deliver at their latency, using the data read at acceptance.

Reset
REQ-025 While rsta_n=0, all output-stage registers, douta and vld_o SHALL be 0, and cnt SHALL be 0.
REQ-026 While rsta_n=0, the state SHALL be CLEAR if AUTO_CLEAR=1, else IDLE; busy SHALL follow the state.
REQ-027 Memory contents SHALL NOT be reset; reset asserted mid-sweep SHALL restart the sweep from address 0.

Verification (NB_COL=4, COL_WIDTH=8, RAM_DEPTH=16)
REQ-028 AUTO_CLEAR=1, release rsta_n -> busy=1 for exactly 16 cycles; then read addr 5 -> douta=0x00000000, vld_o 1 cycle later.
REQ-029 Write-first, latency 1 and 2: write 0xAABBCCDD to addr 3 with wea=1111, then dina=0x11223344 with wea=0101 -> second result 0xAA22CC44 at latency 1 and 2 respectively.
REQ-030 Read-first: same writes -> second write returns 0xAABBCCDD; following read of addr 3 -> 0xAA22CC44.
REQ-031 No-change: read addr 3, then write -> douta stays at the read value, no vld_o for the write, memory updated.
REQ-032 clr pulse, then ena writes during busy -> no vld_o; after 16 cycles all 16 addresses read 0.
REQ-033 rsta_n low at cnt=7 mid-sweep -> douta=0 and vld_o=0 immediately; after release busy=1 for a full 16 cycles.
